// File: rtl/topolar_pipe.sv
// topolar_pipe: pipelined CORDIC rectangular-to-polar converter.
// One signed (x, y) sample per enabled cycle in; phase as an unsigned
// fraction of a full turn out, NSTAGES+2 enabled cycles later.
// Optional feature macro: TOPOLAR_MAG_EN adds the o_mag output (final x,
// scaled by the CORDIC gain). Without it the final x register is not built.
module topolar_pipe #(
  parameter int IW      = 12,
  parameter int PW      = 16,
  parameter int NSTAGES = 12,
  localparam int WW     = IW + 2
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic          i_ce,
  input  logic          i_valid,
  input  logic [IW-1:0] i_xval,
  input  logic [IW-1:0] i_yval,
  output logic          o_valid,
`ifdef TOPOLAR_MAG_EN
  output logic [WW-1:0] o_mag,
`endif
  output logic [PW-1:0] o_phase
);

  // Angle table is held in units of 2^-32 turn and reduced to PW bits
  // with round-half-up; RHALF is half an output LSB (zero when PW = 32).
  localparam int          RSH       = (PW >= 32) ? 0 : 32 - PW;
  localparam logic [32:0] RHALF     = (33'd1 << RSH) >> 1;
  localparam logic [PW-1:0] HALF_TURN = {1'b1, {(PW-1){1'b0}}};

  function automatic logic [PW-1:0] atan_entry(input int idx);
    logic [31:0] tab;
    logic [32:0] rnd;
    case (idx)
      0:       tab = 32'h2000_0000;
      1:       tab = 32'h12E4_051E;
      2:       tab = 32'h09FB_385B;
      3:       tab = 32'h0511_11D4;
      4:       tab = 32'h028B_0D43;
      5:       tab = 32'h0145_D7E1;
      6:       tab = 32'h00A2_F61E;
      7:       tab = 32'h0051_7C55;
      8:       tab = 32'h0028_BE53;
      9:       tab = 32'h0014_5F2F;
      10:      tab = 32'h000A_2F98;
      11:      tab = 32'h0005_17CC;
      12:      tab = 32'h0002_8BE6;
      13:      tab = 32'h0001_45F3;
      14:      tab = 32'h0000_A2FA;
      15:      tab = 32'h0000_517D;
      default: tab = 32'h0000_0000;
    endcase
    rnd = ({1'b0, tab} + RHALF) >> RSH;
    return rnd[PW-1:0];
  endfunction

  // Sign-extended inputs; two guard bits absorb the CORDIC gain (K*sqrt2 < 4).
  logic signed [WW-1:0] x_ext;
  logic signed [WW-1:0] y_ext;
  logic signed [WW-1:0] x_pre;
  logic signed [WW-1:0] y_pre;
  logic [PW-1:0]        ph_pre;

  assign x_ext = {{2{i_xval[IW-1]}}, i_xval};
  assign y_ext = {{2{i_yval[IW-1]}}, i_yval};

  // Fold the left half-plane onto the right by a 180-degree rotation so the
  // micro-rotations only ever have to cover +/-90 degrees.
  always_comb begin
    x_pre  = x_ext;
    y_pre  = y_ext;
    ph_pre = '0;
    if (x_ext[WW-1]) begin
      x_pre  = -x_ext;
      y_pre  = -y_ext;
      ph_pre = HALF_TURN;
    end
  end

  // x_stg[i]/y_stg[i] are the operands entering micro-rotation stage i.
  // ph_stg[i]/v_stg[i] likewise, with index NSTAGES holding the last stage's
  // result. The last stage's x is only registered when magnitude is wanted,
  // and its y is never needed.
  logic signed [WW-1:0] x_stg  [NSTAGES];
  logic signed [WW-1:0] y_stg  [NSTAGES];
  logic [PW-1:0]        ph_stg [NSTAGES+1];
  logic                 v_stg  [NSTAGES+1];

  logic signed [WW-1:0] x_nxt  [NSTAGES];
  logic signed [WW-1:0] y_nxt  [NSTAGES];
  logic [PW-1:0]        ph_nxt [NSTAGES];

  genvar gi;
  generate
    for (gi = 0; gi < NSTAGES; gi++) begin : g_stage
      localparam logic [PW-1:0] ANG = atan_entry(gi);
      logic signed [WW-1:0] x_sh;
      logic signed [WW-1:0] y_sh;
      logic                 y_neg;

      assign x_sh  = x_stg[gi] >>> gi;
      assign y_sh  = y_stg[gi] >>> gi;
      assign y_neg = y_stg[gi][WW-1];

      // Rotate toward the +x axis: direction chosen by the sign of y,
      // accumulating the rotated angle in the phase word (mod 2^PW).
      assign x_nxt[gi]  = y_neg ? (x_stg[gi] - y_sh) : (x_stg[gi] + y_sh);
      assign y_nxt[gi]  = y_neg ? (y_stg[gi] + x_sh) : (y_stg[gi] - x_sh);
      assign ph_nxt[gi] = y_neg ? (ph_stg[gi] - ANG) : (ph_stg[gi] + ANG);
    end
  endgenerate

  // Pipeline registers: prerotation stage feeds stage 0, each stage feeds
  // the next; everything holds when i_ce is low.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NSTAGES; i++) begin
        x_stg[i] <= '0;
        y_stg[i] <= '0;
      end
      for (int i = 0; i <= NSTAGES; i++) begin
        ph_stg[i] <= '0;
        v_stg[i]  <= 1'b0;
      end
    end else if (i_ce) begin
      x_stg[0]  <= x_pre;
      y_stg[0]  <= y_pre;
      ph_stg[0] <= ph_pre;
      v_stg[0]  <= i_valid;
      for (int i = 1; i < NSTAGES; i++) begin
        x_stg[i] <= x_nxt[i-1];
        y_stg[i] <= y_nxt[i-1];
      end
      for (int i = 1; i <= NSTAGES; i++) begin
        ph_stg[i] <= ph_nxt[i-1];
        v_stg[i]  <= v_stg[i-1];
      end
    end
  end

`ifdef TOPOLAR_MAG_EN
  logic signed [WW-1:0] x_fin;

  // Final-stage x, kept alongside ph_stg[NSTAGES] for the magnitude output.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      x_fin <= '0;
    end else if (i_ce) begin
      x_fin <= x_nxt[NSTAGES-1];
    end
  end
`endif

  // Output register: final phase, valid flag and (optionally) magnitude.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid <= 1'b0;
      o_phase <= '0;
`ifdef TOPOLAR_MAG_EN
      o_mag   <= '0;
`endif
    end else if (i_ce) begin
      o_valid <= v_stg[NSTAGES];
      o_phase <= ph_stg[NSTAGES];
`ifdef TOPOLAR_MAG_EN
      o_mag   <= $unsigned(x_fin);
`endif
    end
  end

endmodule

// File: tb/tb_topolar_pipe.sv
// tb_topolar_pipe: scoreboard bench for topolar_pipe (default parameters).
// Expected results come from an integer evaluation of the CORDIC rules and,
// for directed points, a real-valued atan2/hypot sanity check.
module tb_topolar_pipe;
  localparam int IW      = 12;
  localparam int PW      = 16;
  localparam int NSTAGES = 12;
  localparam int WW      = IW + 2;
  localparam int LAT     = NSTAGES + 2;
  localparam int NRAND   = 100;
  localparam real TWO_PI = 6.283185307179586;

  logic          i_clk = 1'b0;
  logic          i_reset_n = 1'b0;
  logic          i_ce = 1'b0;
  logic          i_valid = 1'b0;
  logic [IW-1:0] i_xval = '0;
  logic [IW-1:0] i_yval = '0;
  logic          o_valid;
  logic [PW-1:0] o_phase;
`ifdef TOPOLAR_MAG_EN
  logic [WW-1:0] o_mag;
`endif

  topolar_pipe #(.IW(IW), .PW(PW), .NSTAGES(NSTAGES)) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_ce      (i_ce),
    .i_valid   (i_valid),
    .i_xval    (i_xval),
    .i_yval    (i_yval),
    .o_valid   (o_valid),
`ifdef TOPOLAR_MAG_EN
    .o_mag     (o_mag),
`endif
    .o_phase   (o_phase)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int  ph;
    int  mag;
    int  cap;
    int  run;
    int  idx;
    bit  rchk;
    real rph;
    real rmag;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad = 0;
  int     en_cnt = 0;
  longint ang[NSTAGES];
  real    kgain;
  int     sx[NRAND];
  int     sy[NRAND];
  int     run1_ph[NRAND];
  int     dx[9] = '{1000, 0, -1000, 0, -2048, 2047, 0, 2047, -2048};
  int     dy[9] = '{0, 1000, 0, -1000, -2048, -2047, 0, 2047, 2047};

  function automatic void check(input string name, input longint got, input longint want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endfunction

  function automatic void check_near(input string name, input real got, input real want, input real tol);
    real d;
    total++;
    d = got - want;
    if (d < 0.0) d = -d;
    if (d > tol) begin
      bad++;
      $display("FAIL %s got=%0f want=%0f tol=%0f", name, got, want, tol);
    end
  endfunction

  // Reference: fold to the right half-plane, then NSTAGES rotations that
  // drive y toward zero, summing the table angles; plain 64-bit integers.
  function automatic void model(input int x, input int y, output int ph, output int mag);
    longint cx, cy, p, nx;
    if (x < 0) begin
      cx = -x; cy = -y; p = longint'(1) << (PW - 1);
    end else begin
      cx = x; cy = y; p = 0;
    end
    for (int i = 0; i < NSTAGES; i++) begin
      if (cy < 0) begin
        nx = cx - (cy >>> i); cy = cy + (cx >>> i); p = p - ang[i];
      end else begin
        nx = cx + (cy >>> i); cy = cy - (cx >>> i); p = p + ang[i];
      end
      cx = nx;
    end
    ph  = int'(p & ((longint'(1) << PW) - 1));
    mag = int'(cx);
  endfunction

  // One driven cycle; a captured valid sample pushes its expectation.
  task automatic drive(input bit ce, input bit v, input int x, input int y,
                       input int run, input int idx, input bit rchk);
    exp_t e;
    int   mph, mmag;
    @(posedge i_clk);
    #1;
    i_ce    = ce;
    i_valid = v;
    i_xval  = x[IW-1:0];
    i_yval  = y[IW-1:0];
    if (ce && v && i_reset_n) begin
      model(x, y, mph, mmag);
      if (x == 0 && y == 0) begin
        mph  = 18177;   // sum of the twelve 16-bit table angles
        mmag = 0;
      end
      e.ph   = mph;
      e.mag  = mmag;
      e.cap  = en_cnt + 1;
      e.run  = run;
      e.idx  = idx;
      e.rchk = rchk;
      e.rph  = $atan2(real'(y), real'(x)) / TWO_PI * 65536.0;
      if (e.rph < 0.0) e.rph = e.rph + 65536.0;
      e.rmag = kgain * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
      n++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: counts enabled edges, checks o_valid every enabled cycle,
  // pops and compares results, and checks holding during stalls.
  initial begin
    bit   adv;
    bit   due;
    int   pv, pp;
    exp_t e;
    real  d;
`ifdef TOPOLAR_MAG_EN
    int   pm;
    pm = 0;
`endif
    pv = 0;
    pp = 0;
    forever begin
      @(posedge i_clk);
      adv = i_ce && i_reset_n;
      if (adv) en_cnt++;
      @(negedge i_clk);
      if (i_reset_n) begin
        if (adv) begin
          due = (sb.size() > 0) && (sb[0].cap + NSTAGES + 1 == en_cnt);
          check("valid", o_valid, due);
          if (o_valid && sb.size() > 0) begin
            e = sb.pop_front();
            check("latency", en_cnt - e.cap + 1, LAT);
            check("phase", o_phase, e.ph);
`ifdef TOPOLAR_MAG_EN
            check("mag", o_mag, e.mag);
            if (e.rchk) check_near("mag_real", real'(o_mag), e.rmag, e.rmag * 0.01 + 4.0);
`endif
            if (e.rchk) begin
              d = real'(o_phase) - e.rph;
              while (d > 32768.0) d = d - 65536.0;
              while (d < -32768.0) d = d + 65536.0;
              check_near("phase_real", d, 0.0, 32.0);
            end
            if (e.run == 1) run1_ph[e.idx] = int'(o_phase);
            if (e.run == 2) check("stall_vs_run1", o_phase, run1_ph[e.idx]);
            $display("out run=%0d idx=%0d phase=%0d exp=%0d lat=%0d",
                     e.run, e.idx, o_phase, e.ph, en_cnt - e.cap + 1);
          end
        end else begin
          check("hold_valid", o_valid, pv);
          check("hold_phase", o_phase, pp);
`ifdef TOPOLAR_MAG_EN
          check("hold_mag", o_mag, pm);
`endif
        end
      end
      pv = int'(o_valid);
      pp = int'(o_phase);
`ifdef TOPOLAR_MAG_EN
      pm = int'(o_mag);
`endif
    end
  end

  initial begin
    int  k;
    real a;
    kgain = 1.0;
    for (int i = 0; i < NSTAGES; i++) begin
      a = $atan(1.0 / real'(longint'(1) << i)) / TWO_PI * 4294967296.0;
      ang[i] = (longint'($rtoi(a + 0.5)) + (longint'(1) << (31 - PW))) >>> (32 - PW);
      kgain = kgain * $sqrt(1.0 + 1.0 / real'(longint'(1) << (2 * i)));
    end
    for (int i = 0; i < NRAND; i++) begin
      sx[i] = int'($urandom_range(0, 4095)) - 2048;
      sy[i] = int'($urandom_range(0, 4095)) - 2048;
    end

    // Reset state
    #12;
    check("reset_valid", o_valid, 0);
    check("reset_phase", o_phase, 0);
`ifdef TOPOLAR_MAG_EN
    check("reset_mag", o_mag, 0);
`endif
    @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;
    repeat (3) drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);

    // Axis, diagonal, extreme and (0,0) points back-to-back
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, dx[i], dy[i], 0, i, (i != 6));
    // Valid gap pattern 1,0,0,1
    drive(1'b1, 1'b1, 500, 300, 0, 20, 1'b1);
    drive(1'b1, 1'b0, 123, -45, 0, 0, 1'b0);
    drive(1'b1, 1'b0, -77, 900, 0, 0, 1'b0);
    drive(1'b1, 1'b1, -700, 100, 0, 21, 1'b1);
    drain();

    // Random stream, unstalled
    for (int i = 0; i < NRAND; i++) drive(1'b1, 1'b1, sx[i], sy[i], 1, i, 1'b0);
    drain();

    // Same stream with i_ce toggling; ignored cycles carry garbage
    k = 0;
    while (k < NRAND) begin
      if ($urandom_range(0, 1) == 1) begin
        drive(1'b1, 1'b1, sx[k], sy[k], 2, k, 1'b0);
        k++;
      end else begin
        drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4095)) - 2048,
              int'($urandom_range(0, 4095)) - 2048, 0, 0, 1'b0);
      end
    end
    drain();

    // Reset with 10 samples in flight
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b1, sx[i], sy[i], 0, 30 + i, 1'b0);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    #3;
    i_reset_n = 1'b0;
    #1;
    check("midreset_valid", o_valid, 0);
    check("midreset_phase", o_phase, 0);
`ifdef TOPOLAR_MAG_EN
    check("midreset_mag", o_mag, 0);
`endif
    sb.delete();
    repeat (3) @(posedge i_clk);
    #2;
    i_reset_n = 1'b1;
    repeat (20) drive(1'b1, 1'b0, 0, 0, 0, 0, 1'b0);
    drive(1'b1, 1'b1, 1500, -900, 0, 50, 1'b1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/topolar_pipe.md
# topolar_pipe

Parametrised, fully pipelined CORDIC rectangular-to-polar converter with valid tracking and clock-enable stalling. It accepts one signed (x, y) sample per enabled cycle and produces its phase as an unsigned fraction of a full turn, optionally with the unscaled magnitude. It sits between the coordinate generator and the spiral/pattern logic. It replaces the fixed 7-bit, 3-stage converter.

## Interface
- `IW`, 12, input width of x and y (signed, 4..24)
- `PW`, 16, phase width; the full turn is 2^PW (4..32)
- `NSTAGES`, 12, CORDIC micro-rotation stages (1..16)
- `WW`, IW+2 (localparam), internal working width
- `i_clk` input 1: clock, rising edge
- `i_reset_n` input 1: asynchronous active-low reset
- `i_ce` input 1: clock enable; the pipeline advances only when high
- `i_valid` input 1: the sample on `i_xval`/`i_yval` is valid
- `i_xval` input IW: signed x
- `i_yval` input IW: signed y
- `o_valid` output 1: `o_phase` and `o_mag` are valid
- `o_phase` output PW: angle, unsigned, modulo 2^PW (0 = +x axis, 2^(PW-2) = +y axis)
- `o_mag` output WW: unsigned magnitude times CORDIC gain (present only with `TOPOLAR_MAG_EN`)

## Operation
- Inputs are sign-extended to WW bits. No overflow is possible, because K·√2 < 4.
- **Stage P (prerotation):** if x < 0, then x' = −x, y' = −y, ph = 2^(PW−1). Otherwise x' = x, y' = y, ph = 0. This step has no gain.
- **Stage i (i = 0..NSTAGES−1):**
  - If y[i] < 0: x += y>>>i is replaced by x − (y>>>i), y + (x>>>i), ph − A[i].
  - Otherwise: x + (y>>>i), y − (x>>>i), ph + A[i].
  - All shifts are arithmetic. Phase arithmetic is modulo 2^PW.
- **Angle table A[i]:** atan(2^−i) in units of 2^−32 turn, rounded to nearest, then right-shifted by (32−PW) with round-half-up.
  - Values: 20000000, 12E4051E, 09FB385B, 051111D4, 028B0D43, 0145D7E1, 00A2F61E, 00517C55, 0028BE53, 00145F2F, 000A2F98, 000517CC, 00028BE6, 000145F3, 0000A2FA, 0000517D (hex).
  - Entries that round to 0 still run the x/y rotation.
- **Output register:** `o_phase` is the final ph. `o_mag` is the final x, which is ≥ 0, with gain K = Π√(1+2^−2i), ≈ 1.6468 for NSTAGES ≥ 8.
- **(0,0) input:** not special-cased. The result is deterministic: mag = 0, and phase = the sum of all A[i].
- **Valid tracking:** a valid bit travels alongside each stage. Invalid samples still move through the datapath, but `o_valid` = 0 for them.

## Timing
- Latency is NSTAGES+2 enabled cycles, from a sample captured on `i_ce`·edge to `o_valid`.
  - Registers: stage P, NSTAGES stages, output.
- Throughput is one sample per enabled cycle.
- With `i_ce` = 0, every register holds, including `o_valid` and the outputs. Stalls of any length are lossless.
- **Reset:** on `i_reset_n` low, all data, phase, and valid registers clear immediately.
  - `o_valid` = 0, `o_phase` = 0, `o_mag` = 0.
  - Samples in flight are discarded.
  - After release, the first `o_valid` appears NSTAGES+2 enabled cycles after the first valid input.
- `i_valid` is sampled only when `i_ce` = 1. There is no backpressure and no ready signal.

## Configuration
- `TOPOLAR_MAG_EN`
  - Defined: the `o_mag` port exists and the final x is registered to it.
  - Undefined: the port is absent. The final-stage x register and the output mag register are removed. x is still computed through stage NSTAGES−1, and phase results are bit-identical.

## Test plan
All cases use default parameters with `i_ce` = 1 unless stated.

- **Axis inputs:**
  - (1000, 0) → phase 0x0000 ±2, mag 1647 ±2
  - (0, 1000) → 0x4000 ±2
  - (−1000, 0) → 0x8000 ±2
  - (0, −1000) → 0xC000 ±2
- **Diagonals and extremes:**
  - (−2048, −2048) → phase 0xA000 ±2, mag 4770 ±3, no wrap
  - (2047, −2047) → 0xE000 ±2
- **Latency and throughput:**
  - Feed 100 random valid samples back-to-back.
  - `o_valid` rises exactly 14 cycles after the first input.
  - Results match a real-valued model within ±3 LSB, in order.
- **Stall:**
  - Toggle `i_ce` pseudo-randomly (50%) during the random stream.
  - Output sequence is identical to the unstalled run.
  - Outputs hold while `i_ce` = 0.
- **Reset mid-operation:**
  - Assert `i_reset_n` low asynchronously, between edges, with 10 samples in flight.
  - Outputs go to 0 immediately.
  - After release, no stale `o_valid`.
  - A new sample appears after 14 cycles.
- **Valid gaps:**
  - Send the pattern valid, invalid, invalid, valid.
  - `o_valid` reproduces the pattern 1,0,0,1 after 14 cycles.
